count_sec_carry: RTL

Seconds stage of the clock chip and the transmitting end of the sec60sig carry interface consumed by the minutes counter.
- Divides the system clock down to a 1 Hz tick and counts seconds 0..59.
- Emits a stretched, glitch-free sec60sig pulse on each 59->0 wrap, so the downstream two-flop rising-edge detector always catches it.
- Uses the same state/num/enable set-and-commit protocol as the other time-field counters.

---
 rtl/count_sec_carry.sv | 94 +++++++++
 1 files changed

// File: rtl/count_sec_carry.sv
// Seconds stage of the clock chip: 1 Hz prescaler, 0..59 seconds counter with
// set/commit loading, and the stretched sec60sig carry to the minutes counter.
module count_sec_carry #(
   parameter int CLK_HZ    = 100000000,
   parameter int PULSE_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] state,
   input  logic [5:0] num,
   input  logic       sec_enable,
   output logic [5:0] count,
   output logic       sec60sig,
   output logic       tick_1hz
);

   localparam int              DIV_W    = $clog2(CLK_HZ);
   localparam int              PLS_W    = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
   localparam logic [5:0]      SEC_MAX  = 6'd59;

   typedef enum logic [1:0] {
      MODE_RUN    = 2'b00,
      MODE_SET_A  = 2'b01,
      MODE_SET_B  = 2'b10,
      MODE_COMMIT = 2'b11
   } mode_t;

   mode_t            w_mode;
   logic             w_run;
   logic             w_tick;
   logic             w_wrap;
   logic             w_set;
   logic             w_commit;

   logic [DIV_W-1:0] r_div;
   logic [5:0]       r_count;
   logic [5:0]       r_stage;
   logic             r_sec60;
   logic [PLS_W-1:0] r_pulse_left;
   logic             r_tick;

   assign w_mode   = mode_t'(state);
   assign w_run    = (w_mode == MODE_RUN);
   assign w_tick   = w_run && (r_div == DIV_LAST);
   // Only a genuine 59->0 rollover carries; an out-of-range count reloads silently.
   assign w_wrap   = w_tick && (r_count == SEC_MAX);
   assign w_set    = ((w_mode == MODE_SET_A) || (w_mode == MODE_SET_B)) && sec_enable;
   assign w_commit = (w_mode == MODE_COMMIT) && sec_enable;

   // NOTE: every register here uses non-blocking assignments so all state
   // updates on an edge see the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   r_div <= '0;
      else if (!w_run)           r_div <= '0;
      else if (r_div == DIV_LAST) r_div <= '0;
      else                       r_div <= r_div + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_count <= '0;
      else if (w_commit) r_count <= r_stage;
      else if (w_tick)   r_count <= (r_count >= SEC_MAX) ? 6'd0 : r_count + 6'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_stage <= '0;
      else if (w_set) r_stage <= (num > SEC_MAX) ? SEC_MAX : num;
   end

   // The pulse runs to completion regardless of mode or commits once started.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sec60      <= 1'b0;
         r_pulse_left <= '0;
      end else if (w_wrap) begin
         r_sec60      <= 1'b1;
         r_pulse_left <= PLS_W'(PULSE_LEN - 1);
      end else if (r_sec60) begin
         if (r_pulse_left == '0) r_sec60 <= 1'b0;
         else                    r_pulse_left <= r_pulse_left - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_tick <= 1'b0;
      else     r_tick <= w_tick;
   end

   assign count    = r_count;
   assign sec60sig = r_sec60;
   assign tick_1hz = r_tick;

endmodule
